// File: rtl/msg_schedule_pkg.sv
// Shared SHA-256 message-schedule definitions: sizes, FSM encoding, sigma functions
// and the round-constant table (used only when MSG_SCHDL_WK_SUM_EN is defined).
package msg_schedule_pkg;

  localparam int WRD_SIZE      = 32;
  localparam int MSG_SIZE      = 512;
  localparam int NUM_ROUNDS    = 64;
  localparam int WORDS_PER_BLK = 16;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WRD_SIZE-1:0] K_TABLE [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WRD_SIZE-1:0] ssig0(input logic [WRD_SIZE-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WRD_SIZE-1:0] ssig1(input logic [WRD_SIZE-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Block-in / word-out handshake bundle of the message scheduler.
// master = the scheduler, slave = block source plus round stage.
interface msg_schedule_if;
  import msg_schedule_pkg::*;

  logic                i_blk_valid;
  logic                o_blk_ready;
  logic [MSG_SIZE-1:0] i_msg_blk;
  logic                o_w_valid;
  logic                i_w_ready;
  logic [WRD_SIZE-1:0] o_w;
  logic [5:0]          o_round_idx;
  logic                o_last;

  modport master (
    input  i_blk_valid, i_msg_blk, i_w_ready,
    output o_blk_ready, o_w_valid, o_w, o_round_idx, o_last
  );

  modport slave (
    output i_blk_valid, i_msg_blk, i_w_ready,
    input  o_blk_ready, o_w_valid, o_w, o_round_idx, o_last
  );

endinterface

// File: rtl/msg_schdl_expand.sv
// Combinational next-word expansion for the 16-word sliding window.
module msg_schdl_expand
  import msg_schedule_pkg::*;
(
  input  logic [WRD_SIZE-1:0] w0,
  input  logic [WRD_SIZE-1:0] w1,
  input  logic [WRD_SIZE-1:0] w9,
  input  logic [WRD_SIZE-1:0] w14,
  output logic [WRD_SIZE-1:0] next_w
);

  assign next_w = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message scheduler: takes one 512-bit block, streams W_0..W_63 one per handshake.
// Define MSG_SCHDL_WK_SUM_EN to present W_t + K_t on o_w instead of raw W_t.
module msg_schedule
  import msg_schedule_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  msg_schedule_if.master bus
);

  state_t              state_reg, state_next;
  logic [WRD_SIZE-1:0] win_reg  [WORDS_PER_BLK];
  logic [WRD_SIZE-1:0] win_next [WORDS_PER_BLK];
  logic [WRD_SIZE-1:0] blk_word [WORDS_PER_BLK];
  logic [5:0]          idx_reg, idx_next;
  logic [WRD_SIZE-1:0] w_reg, w_next;
  logic [WRD_SIZE-1:0] exp_word;
  logic                blk_ready_reg, w_valid_reg, last_reg;

  // W_0 sits in the most significant word of the block
  generate
    for (genvar gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_split
      assign blk_word[gi] = bus.i_msg_blk[MSG_SIZE-1-gi*WRD_SIZE -: WRD_SIZE];
    end
  endgenerate

  msg_schdl_expand u_expand (
    .w0     (win_reg[0]),
    .w1     (win_reg[1]),
    .w9     (win_reg[9]),
    .w14    (win_reg[14]),
    .next_w (exp_word)
  );

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_blk_valid) begin
          win_next   = blk_word;
          idx_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_w_ready) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = ST_IDLE;
          end else begin
            for (int k = 0; k < WORDS_PER_BLK - 1; k++) begin
              win_next[k] = win_reg[k+1];
            end
            win_next[WORDS_PER_BLK-1] = exp_word;
            idx_next = idx_reg + 6'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output word is computed from the next window so it is registered with zero extra latency
`ifdef MSG_SCHDL_WK_SUM_EN
  assign w_next = win_next[0] + K_TABLE[idx_next];
`else
  assign w_next = win_next[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      for (int k = 0; k < WORDS_PER_BLK; k++) begin
        win_reg[k] <= '0;
      end
      idx_reg       <= '0;
      w_reg         <= '0;
      blk_ready_reg <= 1'b0;
      w_valid_reg   <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      idx_reg   <= idx_next;
      if (state_next == ST_RUN) begin
        w_reg <= w_next;
      end
      blk_ready_reg <= (state_next == ST_IDLE);
      w_valid_reg   <= (state_next == ST_RUN);
      last_reg      <= (state_next == ST_RUN) && (idx_next == LAST_IDX);
    end
  end

  assign bus.o_blk_ready = blk_ready_reg;
  assign bus.o_w_valid   = w_valid_reg;
  assign bus.o_w         = w_reg;
  assign bus.o_round_idx = idx_reg;
  assign bus.o_last      = last_reg;

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: a FIPS-180 style schedule model feeds an expected queue,
// a negedge monitor pops and compares each consumed word.
module tb_msg_schedule;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msg_schedule_if bus ();

  msg_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ready_mode = 0;
  logic [31:0] mw [64];

`ifdef MSG_SCHDL_WK_SUM_EN
  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Expected stream for one block, pushed at the moment the block is offered
  task automatic push_expected(input logic [511:0] blk, input bit is_abc);
    logic [31:0] s0, s1, word;
    for (int t = 0; t < 16; t++) mw[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
      s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
      mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
    end
    if (is_abc) begin
      mw[16] = 32'h61626380;
      mw[17] = 32'h000F0000;
      mw[18] = 32'h7DA86405;
      mw[19] = 32'h600003C6;
    end
    for (int t = 0; t < 64; t++) begin
      word = mw[t];
`ifdef MSG_SCHDL_WK_SUM_EN
      word = word + TB_K[t];
      if (is_abc && t == 0) word = 32'hA3EC9318;
      if (is_abc && t == 1) word = 32'h71374491;
`endif
      exp_q.push_back('{w: word, idx: 6'(t), last: (t == 63)});
    end
  endtask

  // Round-stage consumer: tied high or ~50% random
  initial begin
    bus.i_w_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_w_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares every consumed word and checks hold-during-stall
  initial begin
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [31:0] held_w = '0;
    logic [5:0]  held_idx = '0;
    forever begin
      @(negedge clk);
      if (stall_prev && bus.o_w_valid)
        check("stall_hold", 64'({bus.o_w, bus.o_round_idx}), 64'({held_w, held_idx}));
      stall_prev = bus.o_w_valid && !bus.i_w_ready;
      held_w     = bus.o_w;
      held_idx   = bus.o_round_idx;
      if (bus.o_w_valid && bus.i_w_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(bus.o_round_idx), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'({bus.o_w, bus.o_round_idx, bus.o_last}), 64'({e.w, e.idx, e.last}));
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_blk_ready", 64'(bus.o_blk_ready), 64'(0));
    check("rst_w_valid", 64'(bus.o_w_valid), 64'(0));
    check("rst_w", 64'(bus.o_w), 64'(0));
    check("rst_round_idx", 64'(bus.o_round_idx), 64'(0));
    check("rst_last", 64'(bus.o_last), 64'(0));
  endtask

  task automatic send_block(input logic [511:0] blk, input bit is_abc);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = bus.o_blk_ready;
    end
    if (!got) begin
      check("blk_ready_timeout", 64'(0), 64'(1));
      return;
    end
    bus.i_msg_blk   = blk;
    bus.i_blk_valid = 1'b1;
    push_expected(blk, is_abc);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.i_blk_valid = 1'b0;
    @(negedge clk);
    check("w0_latency", 64'({bus.o_w_valid, bus.o_blk_ready}), 64'(2'b10));
  endtask

  task automatic wait_done(input bit check_period);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = bus.o_blk_ready;
    end
    if (!got) check("done_timeout", 64'(0), 64'(1));
    else if (check_period) check("ready_period", 64'(cyc - acc_cyc), 64'(65));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_idx(input int n, output bit found);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = bus.o_w_valid && (int'(bus.o_round_idx) == n);
    end
    if (!found) check("wait_idx_timeout", 64'(n), 64'(0));
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] blk;
    bit           found;
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    bus.i_blk_valid = 1'b0;
    bus.i_msg_blk   = '0;

    // Reset and release
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_before_edge", 64'(bus.o_blk_ready), 64'(0));
    @(negedge clk);
    check("ready_after_release", 64'({bus.o_blk_ready, bus.o_w_valid, bus.o_w}), 64'({1'b1, 1'b0, 32'h0}));

    // "abc" with the round stage always ready
    ready_mode = 0;
    send_block(abc_blk, 1'b1);
    wait_done(1'b1);

    // Same block under random back-pressure
    ready_mode = 1;
    send_block(abc_blk, 1'b1);
    wait_done(1'b0);

    // Block offer during RUN must be ignored
    blk = rand_block();
    send_block(blk, 1'b0);
    wait_idx(20, found);
    if (found) begin
      bus.i_msg_blk   = rand_block();
      bus.i_blk_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("ready_low_in_run", 64'(bus.o_blk_ready), 64'(0));
      end
      bus.i_blk_valid = 1'b0;
    end
    wait_done(1'b0);

    // Reset mid-block, coinciding with a block offer
    blk = rand_block();
    send_block(blk, 1'b0);
    wait_idx(30, found);
    if (found) begin
      reset           = 1'b1;
      bus.i_msg_blk   = rand_block();
      bus.i_blk_valid = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      @(negedge clk);
      check_reset_values();
      reset           = 1'b0;
      bus.i_blk_valid = 1'b0;
      @(negedge clk);
      check("ready_after_midrst", 64'({bus.o_blk_ready, bus.o_w_valid}), 64'(2'b10));
    end
    blk = rand_block();
    send_block(blk, 1'b0);
    wait_done(1'b0);

    // A few more random blocks
    for (int b = 0; b < 3; b++) begin
      ready_mode = b % 2;
      send_block(rand_block(), 1'b0);
      wait_done(b % 2 == 0);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
